// File: rtl/uart_pkg.sv
// Shared definitions for the logic-analyzer UART receive path.
// Holds the receiver state encoding, frame width default and legal baud floor.
package uart_pkg;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int BAUD_W            = 16;
    localparam int BAUD_MIN          = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Divisors below the floor would make the half-bit reload underflow.
    function automatic logic [BAUD_W-1:0] clamp_baud(input logic [BAUD_W-1:0] baud);
        return (baud < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the raw RX probe plus falling-edge detector.
// Every flop presets high so a reset release on an idle line cannot look like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '1;
            prev   <= 1'b1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], rx};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Baud-accurate UART frame receiver feeding the protocol trigger stage.
// Samples each bit mid-period and emits one validated byte per frame with a one-cycle strobe.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic [BAUD_W-1:0]    baud_cnt,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 frm_err,
    output logic                 busy
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
        $error("uart_rx_frame: DATA_BITS must be 5..8");
    end

    logic                 sync;
    logic                 fall;
    rx_state_e            state;
    logic [BAUD_W-1:0]    baud_lat;
    logic [BAUD_W-1:0]    bit_timer;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 sample;
    logic [BAUD_W-1:0]    baud_new;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (RX),
        .sync (sync),
        .fall (fall)
    );

    assign sample   = (bit_timer == '0);
    assign baud_new = clamp_baud(baud_cnt);

    // Divisor is captured once per frame so a host rewrite only affects the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_lat  <= '0;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            frm_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_lat  <= baud_new;
                        bit_timer <= (baud_new >> 1) - BAUD_W'(1);
                        state     <= START;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!sync) begin
                            bit_timer <= baud_lat - BAUD_W'(1);
                            bit_idx   <= '0;
                            state     <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_timer <= bit_timer - BAUD_W'(1);
                    end
                end
                // LSB arrives first, so shifting in at the top leaves it at bit 0.
                DATA: begin
                    if (sample) begin
                        shift_reg <= {sync, shift_reg[DATA_BITS-1:1]};
                        bit_timer <= baud_lat - BAUD_W'(1);
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_timer <= bit_timer - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (sample) begin
                        if (sync) begin
                            rx_data <= shift_reg;
                            rx_rdy  <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        bit_timer <= bit_timer - BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames
// compared against a timing/content model derived from frame arithmetic.
module tb_uart_rx_frame;

    localparam int LOG_LEN = 50000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic [15:0] baud_cnt = 16'd16;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        frm_err;
    logic        busy;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } ev_t;

    ev_t        rdy_q[$];
    int         err_q[$];
    logic       busy_log [0:LOG_LEN-1];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_frame #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .baud_cnt (baud_cnt),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .frm_err  (frm_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are observed mid-cycle; each record is tagged with the edge that produced it.
    always @(negedge clk) begin
        if (rx_rdy) rdy_q.push_back('{cyc, rx_data});
        if (frm_err) err_q.push_back(cyc);
        if (cyc < LOG_LEN) busy_log[cyc] = busy;
    end

    function automatic int stop_edge(input int k, input int n);
        return k + 2 + (n / 2) + 9 * n;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit, output int k);
        k = cyc + 1;
        RX = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (p) @(negedge clk);
        end
        RX = stop_bit;
        repeat (p) @(negedge clk);
    endtask

    task automatic idle_high(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_cmp++; if (rx_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_rdy: got %b expected 0", rx_rdy); end
        n_cmp++; if (frm_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frm_err: got %b expected 0", frm_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL release_busy: got %b expected 0", busy); end
        n_cmp++; if (rdy_q.size() + err_q.size() != 0) begin n_fail++; $display("[TB] FAIL release_events: got %0d expected 0", rdy_q.size() + err_q.size()); end
    endtask

    task automatic test_single_frame;
        int k;
        rdy_q.delete(); err_q.delete();
        baud_cnt = 16'd16;
        send_frame(8'hA5, 16, 1'b1, k);
        last_good = 8'hA5;
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 1) begin n_fail++; $display("[TB] FAIL a5_rdy_count: got %0d expected 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            n_cmp++; if (rdy_q[0].cyc != stop_edge(k, 16)) begin n_fail++; $display("[TB] FAIL a5_rdy_edge: got %0d expected %0d", rdy_q[0].cyc, stop_edge(k, 16)); end
            n_cmp++; if (rdy_q[0].data !== 8'hA5) begin n_fail++; $display("[TB] FAIL a5_data: got %h expected a5", rdy_q[0].data); end
        end
        n_cmp++; if (err_q.size() != 0) begin n_fail++; $display("[TB] FAIL a5_err_count: got %0d expected 0", err_q.size()); end
        n_cmp++; if (busy_log[k + 1] !== 1'b0) begin n_fail++; $display("[TB] FAIL a5_busy_before: got %b expected 0", busy_log[k + 1]); end
        n_cmp++; if (busy_log[k + 2] !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_busy_rise: got %b expected 1", busy_log[k + 2]); end
        n_cmp++; if (busy_log[k + 153] !== 1'b1) begin n_fail++; $display("[TB] FAIL a5_busy_last: got %b expected 1", busy_log[k + 153]); end
        n_cmp++; if (busy_log[k + 154] !== 1'b0) begin n_fail++; $display("[TB] FAIL a5_busy_fall: got %b expected 0", busy_log[k + 154]); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL a5_hold: got %h expected a5", rx_data); end
    endtask

    task automatic test_back_to_back;
        int k1, k2;
        rdy_q.delete(); err_q.delete();
        send_frame(8'h3C, 16, 1'b1, k1);
        send_frame(8'hC3, 16, 1'b1, k2);
        last_good = 8'hC3;
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 2) begin n_fail++; $display("[TB] FAIL b2b_rdy_count: got %0d expected 2", rdy_q.size()); end
        if (rdy_q.size() >= 2) begin
            n_cmp++; if (rdy_q[0].data !== 8'h3C) begin n_fail++; $display("[TB] FAIL b2b_data0: got %h expected 3c", rdy_q[0].data); end
            n_cmp++; if (rdy_q[1].data !== 8'hC3) begin n_fail++; $display("[TB] FAIL b2b_data1: got %h expected c3", rdy_q[1].data); end
            n_cmp++; if (rdy_q[1].cyc - rdy_q[0].cyc != 160) begin n_fail++; $display("[TB] FAIL b2b_spacing: got %0d expected 160", rdy_q[1].cyc - rdy_q[0].cyc); end
            n_cmp++; if (rdy_q[0].cyc != stop_edge(k1, 16)) begin n_fail++; $display("[TB] FAIL b2b_edge0: got %0d expected %0d", rdy_q[0].cyc, stop_edge(k1, 16)); end
        end
        n_cmp++; if (err_q.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_err_count: got %0d expected 0", err_q.size()); end
    endtask

    task automatic test_frame_error;
        int k;
        rdy_q.delete(); err_q.delete();
        send_frame(8'h55, 16, 1'b0, k);
        repeat (100) @(negedge clk);
        n_cmp++; if (err_q.size() != 1) begin n_fail++; $display("[TB] FAIL ferr_count: got %0d expected 1", err_q.size()); end
        if (err_q.size() >= 1) begin
            n_cmp++; if (err_q[0] != stop_edge(k, 16)) begin n_fail++; $display("[TB] FAIL ferr_edge: got %0d expected %0d", err_q[0], stop_edge(k, 16)); end
        end
        n_cmp++; if (rdy_q.size() != 0) begin n_fail++; $display("[TB] FAIL ferr_no_rdy: got %0d expected 0", rdy_q.size()); end
        n_cmp++; if (rx_data !== last_good) begin n_fail++; $display("[TB] FAIL ferr_hold: got %h expected %h", rx_data, last_good); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL break_busy: got %b expected 0", busy); end
        rdy_q.delete(); err_q.delete();
        idle_high(20);
        send_frame(8'h96, 16, 1'b1, k);
        last_good = 8'h96;
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 1 || err_q.size() != 0) begin n_fail++; $display("[TB] FAIL rearm_events: got rdy=%0d err=%0d expected rdy=1 err=0", rdy_q.size(), err_q.size()); end
        if (rdy_q.size() >= 1) begin
            n_cmp++; if (rdy_q[0].data !== 8'h96 || rdy_q[0].cyc != stop_edge(k, 16)) begin n_fail++; $display("[TB] FAIL rearm_frame: got %h@%0d expected 96@%0d", rdy_q[0].data, rdy_q[0].cyc, stop_edge(k, 16)); end
        end
    endtask

    task automatic test_glitch;
        int k;
        rdy_q.delete(); err_q.delete();
        RX = 1'b0;
        repeat (4) @(negedge clk);
        idle_high(40);
        n_cmp++; if (rdy_q.size() + err_q.size() != 0) begin n_fail++; $display("[TB] FAIL glitch_events: got %0d expected 0", rdy_q.size() + err_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy); end
        send_frame(8'h81, 16, 1'b1, k);
        last_good = 8'h81;
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 1) begin n_fail++; $display("[TB] FAIL glitch_next_count: got %0d expected 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            n_cmp++; if (rdy_q[0].data !== 8'h81 || rdy_q[0].cyc != stop_edge(k, 16)) begin n_fail++; $display("[TB] FAIL glitch_next_frame: got %h@%0d expected 81@%0d", rdy_q[0].data, rdy_q[0].cyc, stop_edge(k, 16)); end
        end
    endtask

    task automatic test_reset_abort;
        int k;
        rdy_q.delete(); err_q.delete();
        RX = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = 1'b1;
            repeat (16) @(negedge clk);
        end
        RX = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy_pre: got %b expected 1", busy); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_in_reset: got busy=%b data=%h expected busy=0 data=00", busy, rx_data); end
        rst = 1'b0;
        last_good = 8'h00;
        idle_high(200);
        n_cmp++; if (rdy_q.size() + err_q.size() != 0) begin n_fail++; $display("[TB] FAIL abort_events: got %0d expected 0", rdy_q.size() + err_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_release_busy: got %b expected 0", busy); end
        send_frame(8'h12, 16, 1'b1, k);
        last_good = 8'h12;
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 1) begin n_fail++; $display("[TB] FAIL abort_next_count: got %0d expected 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            n_cmp++; if (rdy_q[0].data !== 8'h12 || rdy_q[0].cyc != stop_edge(k, 16)) begin n_fail++; $display("[TB] FAIL abort_next_frame: got %h@%0d expected 12@%0d", rdy_q[0].data, rdy_q[0].cyc, stop_edge(k, 16)); end
        end
    endtask

    task automatic test_baud_change;
        int         k1, k2;
        logic [7:0] b;
        rdy_q.delete(); err_q.delete();
        baud_cnt = 16'd16;
        b = 8'h6B;
        k1 = cyc + 1;
        RX = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            if (i == 2) begin
                repeat (5) @(negedge clk);
                baud_cnt = 16'd32;
                repeat (11) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        idle_high(26);
        send_frame(8'hD4, 32, 1'b1, k2);
        idle_high(20);
        n_cmp++; if (rdy_q.size() != 2) begin n_fail++; $display("[TB] FAIL baud_rdy_count: got %0d expected 2", rdy_q.size()); end
        if (rdy_q.size() >= 2) begin
            n_cmp++; if (rdy_q[0].data !== 8'h6B || rdy_q[0].cyc != stop_edge(k1, 16)) begin n_fail++; $display("[TB] FAIL baud_old_frame: got %h@%0d expected 6b@%0d", rdy_q[0].data, rdy_q[0].cyc, stop_edge(k1, 16)); end
            n_cmp++; if (rdy_q[1].data !== 8'hD4 || rdy_q[1].cyc != k2 + 2 + 16 + 288) begin n_fail++; $display("[TB] FAIL baud_new_frame: got %h@%0d expected d4@%0d", rdy_q[1].data, rdy_q[1].cyc, k2 + 306); end
        end
        last_good = 8'hD4;
        baud_cnt = 16'd16;
    endtask

    task automatic test_random_frames;
        ev_t        exp_rdy[$];
        int         exp_err[$];
        int         k, n, gap;
        logic [7:0] b;
        logic       stop_bit;
        rdy_q.delete(); err_q.delete();
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(20, 4);
            b = 8'($urandom);
            stop_bit = ($urandom_range(9, 0) != 0);
            baud_cnt = 16'(n);
            send_frame(b, n, stop_bit, k);
            if (stop_bit) begin
                exp_rdy.push_back('{stop_edge(k, n), b});
                last_good = b;
                gap = $urandom_range(5, 0);
            end else begin
                exp_err.push_back(stop_edge(k, n));
                gap = $urandom_range(5, 1);
            end
            idle_high(gap);
        end
        idle_high(30);
        n_cmp++; if (rdy_q.size() != exp_rdy.size()) begin n_fail++; $display("[TB] FAIL rand_rdy_count: got %0d expected %0d", rdy_q.size(), exp_rdy.size()); end
        n_cmp++; if (err_q.size() != exp_err.size()) begin n_fail++; $display("[TB] FAIL rand_err_count: got %0d expected %0d", err_q.size(), exp_err.size()); end
        for (int i = 0; i < exp_rdy.size() && i < rdy_q.size(); i++) begin
            n_cmp++;
            if (rdy_q[i].data !== exp_rdy[i].data || rdy_q[i].cyc != exp_rdy[i].cyc) begin
                n_fail++;
                $display("[TB] FAIL rand_rdy[%0d]: got %h@%0d expected %h@%0d", i, rdy_q[i].data, rdy_q[i].cyc, exp_rdy[i].data, exp_rdy[i].cyc);
            end
        end
        for (int i = 0; i < exp_err.size() && i < err_q.size(); i++) begin
            n_cmp++;
            if (err_q[i] != exp_err[i]) begin
                n_fail++;
                $display("[TB] FAIL rand_err[%0d]: got %0d expected %0d", i, err_q[i], exp_err[i]);
            end
        end
        n_cmp++; if (rx_data !== last_good) begin n_fail++; $display("[TB] FAIL rand_hold: got %h expected %h", rx_data, last_good); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_frame_error;
        test_glitch;
        test_reset_abort;
        test_baud_change;
        test_random_frames;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Baud-accurate UART receiver that sits directly upstream of the UART protocol trigger in the logic-analyzer trigger path. It synchronizes the raw RX probe line and detects start bits. It samples each bit at mid-period using the runtime baud_cnt and emits one validated byte per frame with a single-cycle strobe. The trigger stage compares that byte against match/mask instead of a free-running shift register.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first. Legal range 5..8.
SYNC_STAGES, 2, metastability flops on RX ahead of edge detection. Fixed at 2 for the latency figures below.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
RX  input  1  raw asynchronous serial line, idle high
baud_cnt  input  16  clocks per bit period; legal ≥ 4; latched at start-edge detection, mid-frame changes ignored
rx_data  output  DATA_BITS  last good byte; held until next good frame; reset 0
rx_rdy  output  1  one-cycle pulse when rx_data updates; reset 0
frm_err  output  1  one-cycle pulse on bad stop bit; reset 0
busy  output  1  high in any state other than IDLE; reset 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: synchronizer and previous-sample flops preset to 1, so no false start on release. FSM goes to IDLE, counters 0, shift register 0, latched baud 0.
- Reset asserted mid-frame aborts the frame immediately. No rx_rdy or frm_err is produced for that frame.
- Falling-edge detect: fall = prev & ~sync, using the last synchronizer stage and one further delay flop. Nominal edge-to-detect latency is 2 clocks.
- Bit timer: a down counter. A sample event occurs on a clock edge where the counter equals 0; the counter reloads on that same edge.
- FSM states: IDLE, START, DATA, STOP.
- IDLE to START: on fall. Latch baud_cnt as N. Load counter with (N>>1)-1.
- START at a sample event:
  - sync = 0: go to DATA, load counter N-1, clear bit index.
  - sync = 1 (glitch, false start): go to IDLE. No outputs.
- DATA at a sample event:
  - Shift sync into the shift register MSB, right-shifting, so the bit first received ends at bit 0.
  - Increment the bit index and reload the counter N-1.
  - After DATA_BITS samples, go to STOP.
- STOP at a sample event:
  - sync = 1: rx_data gets the shift register and rx_rdy pulses.
  - sync = 0: frm_err pulses and rx_data is unchanged.
  - Both cases go to IDLE.
- Outputs are registered. The pulse is high for exactly the one cycle after the stop-sample edge.
- Latency: if edge t0 is the first clock edge sampling RX low, the stop sample occurs at edge t0+2+(N>>1)+9N. For DATA_BITS=8 the rdy/err pulse is visible in the following cycle.
- Re-arm: IDLE needs a fresh high-to-low transition.
  - A held-low break line produces one frm_err, then nothing until RX returns high and falls again.
  - A start bit arriving immediately after a valid stop is detected (back-to-back frames supported).
- busy deasserts on the same edge the FSM enters IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/STOP);
  - DATA_BITS default;
  - minimum legal baud constant (4).
- Sub-module uart_rx_sync:
  - SYNC_STAGES flops plus delay flop, all preset high on rst;
  - outputs the synchronized level and the fall pulse.
- The FSM, bit timer and shift register stay in uart_rx_frame.

Test Plan:
- baud_cnt=16, send 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) with RX first low at edge k -> rx_rdy high for exactly one cycle after edge k+154, rx_data=0xA5, frm_err=0, busy high from k+2 to k+154.
- baud_cnt=16, 0x3C followed immediately by 0xC3 with no idle gap -> two rx_rdy pulses 160 cycles apart, data 0x3C then 0xC3.
- baud_cnt=16, stop bit driven 0 on byte 0x55 -> frm_err one-cycle pulse, no rx_rdy, rx_data keeps its previous value. RX then held low 100 cycles -> no further pulses until a new fall.
- baud_cnt=16, RX low pulse of 4 cycles then high -> returns to IDLE after the START sample, no rx_rdy/frm_err. A following valid 0x81 is received correctly.
- rst asserted at data bit 4 of a 0xFF frame, released, then 0x12 sent -> no output for the aborted frame, rx_rdy with 0x12, no spurious start at reset release.
- baud_cnt changed from 16 to 32 at data bit 2 -> frame still decoded at 16 clocks/bit. The next frame decodes at 32 (rdy at edge k+2+16+288).
